decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter: HAZARD_CYCLES, default 1, number of bubbles inserted per load-use hazard; legal range 1..3.
REQ-002 Clock and reset: one clock, clk_i; reset_i is synchronous and active-high.
REQ-003 Ports, as name direction width meaning:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  synchronous active-high reset.
- valid_i  in  1  fetch output is valid.
- inst_i  in  32  fetched ARM instruction.
- pc_i  in  32  PC of inst_i.
- flush_i  in  1  branch or PC write resolved; kill the instruction being decoded.
- stall_i  in  1  downstream stall; hold all outputs.
- stall_o  out  1  load-use hazard; fetch holds its PC.
- valid_o  out  1  decoded bundle valid.
- pc_o  out  32  PC of the decoded instruction.
- cond_o  out  4  inst[31:28].
- class_o  out  2  00 data-processing, 01 load/store, 10 branch, 11 undefined.
- opcode_o  out  4  inst[24:21].
- s_o, imm_o  out  1 each  inst[20] and inst[25].
- rn_o, rd_o, rm_o  out  4 each  inst[19:16], inst[15:12], inst[3:0].
- operand2_o  out  12  inst[11:0].
- load_o, store_o  out  1 each  LDR and STR (class 01, with L = inst[20]).
- branch_o, link_o  out  1 each  B/BL, with link = inst[24].
- branch_offset_o  out  24  inst[23:0].
- wb_pc_o  out  1  the instruction writes R15.

Function
REQ-004 Classification SHALL use inst[27:26]: 00 is DP, 01 is LDR/STR, 10 with inst[25]=1 is branch, and every other encoding is undefined.
REQ-005 All outputs except stall_o SHALL be registered, with a latency of one cycle from inst_i to the outputs.
REQ-006 When stall_i=1, all registered outputs SHALL hold their values, and the hazard counter SHALL freeze.
REQ-007 When flush_i=1 and stall_i=0, valid_o SHALL be 0 on the next cycle and the other fields are don't-care; flush_i SHALL take priority over a hazard.
REQ-008 valid_o SHALL be 0 for any undefined class; the instruction is dropped.
REQ-009 The hazard condition SHALL be all of the following:
- registered valid_o=1 and load_o=1, and
- valid_i=1, and
- rd_o equals the new instruction's rn (DP and load/store), or its rm (DP register form, or load/store with inst[25]=1).
REQ-010 The hazard state machine SHALL have two states, IDLE and BUBBLE, with a counter of width 2:
- IDLE to BUBBLE when a hazard is detected; the counter loads HAZARD_CYCLES-1.
- BUBBLE decrements the counter each unstalled cycle and returns to IDLE at 0.
REQ-011 stall_o SHALL be 1 combinationally in IDLE when a hazard is detected, and throughout BUBBLE.
REQ-012 While stall_o=1, the registered valid_o SHALL be 0 (bubble), and inst_i SHALL NOT be captured.
REQ-013 wb_pc_o SHALL be 1 only for a valid DP instruction with rd=15 and opcode not in 1000..1011, or a valid LDR with rd=15.
REQ-014 flush_i SHALL force IDLE, clear the counter and deassert stall_o in the same cycle.
REQ-015 The block SHALL contain no arithmetic on the PC; pc_o is pc_i delayed by one cycle.

Reset
REQ-016 When reset_i=1 at a clock edge, the following SHALL apply:
- valid_o, load_o, store_o, branch_o, link_o and wb_pc_o are 0.
- Every other output field is 0.
- The FSM is IDLE and the counter is 0.
REQ-017 reset_i SHALL override stall_i and flush_i, and stall_o SHALL be 0 while reset_i=1.
REQ-018 A reset asserted in BUBBLE SHALL abandon the bubble; the first instruction after reset decodes with no stall.

Configuration
REQ-019 The macro DECODE_HAZARD_EN SHALL control the hazard logic:
- Defined: REQ-009 to REQ-012 are active.
- Undefined: there is no FSM or counter, stall_o is tied to 0, every valid instruction is decoded, and forwarding or software is responsible for load-use.

Verification
REQ-020 Reset then ADD R1,R2,R3 (0xE0821003) with valid_i=1 SHALL give, one cycle later, valid_o=1, class_o=00, opcode_o=0100, rn_o=2, rd_o=1, rm_o=3 and stall_o=0.
REQ-021 LDR R4,[R5] (0xE5954000) followed by ADD R6,R4,R1 (0xE0846001), with the macro defined and HAZARD_CYCLES=1, SHALL give:
- stall_o=1 for one cycle,
- valid_o=0 for one bubble,
- then the ADD with valid_o=1.
REQ-022 The same sequence with HAZARD_CYCLES=3 SHALL give stall_o=1 for 3 cycles and 3 bubbles.
REQ-023 BL with 0xEB000010 SHALL give class_o=10, branch_o=1, link_o=1 and branch_offset_o=0x000010; flush_i=1 on the next cycle SHALL give valid_o=0.
REQ-024 MOV PC,LR (0xE1A0F00E) SHALL give wb_pc_o=1; CMP R15,#0 SHALL give wb_pc_o=0; and stall_i=1 for 2 cycles SHALL hold every output.
REQ-025 Asserting reset_i during BUBBLE SHALL give, on the next cycle, stall_o=0, valid_o=0 and the FSM in IDLE.

Source files
------------

// File: rtl/decode.sv
// decode: ARM instruction decoder; load-use hazard bubbles exist only with DECODE_HAZARD_EN defined.
// Latency: 1 cycle from inst_i to every output except stall_o, which is combinational.
// Backpressure: stall_i freezes outputs and the hazard counter; stall_o asks fetch to hold its PC.
module decode #(
  parameter int HAZARD_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [3:0]  cond_o,
  output logic [1:0]  class_o,
  output logic [3:0]  opcode_o,
  output logic        s_o,
  output logic        imm_o,
  output logic [3:0]  rn_o,
  output logic [3:0]  rd_o,
  output logic [3:0]  rm_o,
  output logic [11:0] operand2_o,
  output logic        load_o,
  output logic        store_o,
  output logic        branch_o,
  output logic        link_o,
  output logic [23:0] branch_offset_o,
  output logic        wb_pc_o
);

  if (HAZARD_CYCLES < 1 || HAZARD_CYCLES > 3) begin : g_bad_hazard_cycles
    $error("decode: HAZARD_CYCLES must be in 1..3");
  end

  typedef struct packed {
    logic [1:0] cls;
    logic       defined;
    logic       load;
    logic       store;
    logic       branch;
    logic       link;
    logic       wb_pc;
  } dec_t;

  logic is_dp;
  logic is_ls;
  logic is_br;
  logic take;
  dec_t dec;

  assign is_dp = (inst_i[27:26] == 2'b00);
  assign is_ls = (inst_i[27:26] == 2'b01);
  assign is_br = (inst_i[27:26] == 2'b10) && inst_i[25];

  always_comb begin
    dec         = '0;
    dec.cls     = 2'b11;
    dec.defined = is_dp | is_ls | is_br;
    if (is_dp) begin
      dec.cls = 2'b00;
    end else if (is_ls) begin
      dec.cls = 2'b01;
    end else if (is_br) begin
      dec.cls = 2'b10;
    end
    dec.load   = is_ls & inst_i[20];
    dec.store  = is_ls & ~inst_i[20];
    dec.branch = is_br;
    dec.link   = is_br & inst_i[24];
    // TST/TEQ/CMP/CMN (opcode 10xx) only set flags, so rd=15 does not write the PC
    dec.wb_pc  = (inst_i[15:12] == 4'hF) &&
                 ((is_dp && (inst_i[24:23] != 2'b10)) || (is_ls && inst_i[20]));
  end

`ifdef DECODE_HAZARD_EN
  typedef enum logic {IDLE, BUBBLE} state_e;

  localparam logic [1:0] HC_LOAD = 2'(HAZARD_CYCLES - 1);

  state_e     state;
  logic [1:0] cnt;
  logic       uses_rn;
  logic       uses_rm;
  logic       hazard;

  assign uses_rn = is_dp | is_ls;
  assign uses_rm = (is_dp & ~inst_i[25]) | (is_ls & inst_i[25]);
  assign hazard  = valid_o & load_o & valid_i &
                   ((uses_rn & (rd_o == inst_i[19:16])) |
                    (uses_rm & (rd_o == inst_i[3:0])));
  assign stall_o = ~reset_i & ~flush_i &
                   (((state == IDLE) & hazard) | (state == BUBBLE));

  // The detection cycle is itself the first bubble, so BUBBLE covers the remaining HAZARD_CYCLES-1.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else if (!stall_i) begin
      unique case (state)
        IDLE: begin
          if (hazard) begin
            cnt   <= HC_LOAD;
            state <= (HC_LOAD != 2'd0) ? BUBBLE : IDLE;
          end
        end
        BUBBLE: begin
          cnt <= cnt - 2'd1;
          if (cnt <= 2'd1) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 2'd0;
        end
      endcase
    end
  end
`else
  assign stall_o = 1'b0;
`endif

  assign take = valid_i & ~flush_i & ~stall_o & dec.defined;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_o         <= 1'b0;
      pc_o            <= 32'd0;
      cond_o          <= 4'd0;
      class_o         <= 2'd0;
      opcode_o        <= 4'd0;
      s_o             <= 1'b0;
      imm_o           <= 1'b0;
      rn_o            <= 4'd0;
      rd_o            <= 4'd0;
      rm_o            <= 4'd0;
      operand2_o      <= 12'd0;
      load_o          <= 1'b0;
      store_o         <= 1'b0;
      branch_o        <= 1'b0;
      link_o          <= 1'b0;
      branch_offset_o <= 24'd0;
      wb_pc_o         <= 1'b0;
    end else if (!stall_i) begin
      valid_o  <= take;
      load_o   <= take & dec.load;
      store_o  <= take & dec.store;
      branch_o <= take & dec.branch;
      link_o   <= take & dec.link;
      wb_pc_o  <= take & dec.wb_pc;
      // Fields hold through a bubble so rd_o keeps naming the load's destination
      if (!stall_o) begin
        pc_o            <= pc_i;
        cond_o          <= inst_i[31:28];
        class_o         <= dec.cls;
        opcode_o        <= inst_i[24:21];
        s_o             <= inst_i[20];
        imm_o           <= inst_i[25];
        rn_o            <= inst_i[19:16];
        rd_o            <= inst_i[15:12];
        rm_o            <= inst_i[3:0];
        operand2_o      <= inst_i[11:0];
        branch_offset_o <= inst_i[23:0];
      end
    end
  end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: two instances (HAZARD_CYCLES 1 and 3) share all inputs.
module tb_decode;

  logic        clk_i = 1'b0;
  logic        reset_i, valid_i, flush_i, stall_i;
  logic [31:0] inst_i, pc_i;

  logic        stall_o, valid_o, s_o, imm_o, load_o, store_o, branch_o, link_o, wb_pc_o;
  logic [31:0] pc_o;
  logic [3:0]  cond_o, opcode_o, rn_o, rd_o, rm_o;
  logic [1:0]  class_o;
  logic [11:0] operand2_o;
  logic [23:0] branch_offset_o;

  logic        u3_stall_o, u3_valid_o, u3_s_o, u3_imm_o, u3_load_o, u3_store_o;
  logic        u3_branch_o, u3_link_o, u3_wb_pc_o;
  logic [31:0] u3_pc_o;
  logic [3:0]  u3_cond_o, u3_opcode_o, u3_rn_o, u3_rd_o, u3_rm_o;
  logic [1:0]  u3_class_o;
  logic [11:0] u3_operand2_o;
  logic [23:0] u3_branch_offset_o;

  int total = 0;
  int bad   = 0;

`ifdef DECODE_HAZARD_EN
  localparam logic HAZ = 1'b1;
`else
  localparam logic HAZ = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  decode #(.HAZARD_CYCLES(1)) u1 (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .inst_i(inst_i), .pc_i(pc_i),
    .flush_i(flush_i), .stall_i(stall_i), .stall_o(stall_o), .valid_o(valid_o), .pc_o(pc_o),
    .cond_o(cond_o), .class_o(class_o), .opcode_o(opcode_o), .s_o(s_o), .imm_o(imm_o),
    .rn_o(rn_o), .rd_o(rd_o), .rm_o(rm_o), .operand2_o(operand2_o), .load_o(load_o),
    .store_o(store_o), .branch_o(branch_o), .link_o(link_o),
    .branch_offset_o(branch_offset_o), .wb_pc_o(wb_pc_o)
  );

  decode #(.HAZARD_CYCLES(3)) u3 (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .inst_i(inst_i), .pc_i(pc_i),
    .flush_i(flush_i), .stall_i(stall_i), .stall_o(u3_stall_o), .valid_o(u3_valid_o),
    .pc_o(u3_pc_o), .cond_o(u3_cond_o), .class_o(u3_class_o), .opcode_o(u3_opcode_o),
    .s_o(u3_s_o), .imm_o(u3_imm_o), .rn_o(u3_rn_o), .rd_o(u3_rd_o), .rm_o(u3_rm_o),
    .operand2_o(u3_operand2_o), .load_o(u3_load_o), .store_o(u3_store_o),
    .branch_o(u3_branch_o), .link_o(u3_link_o), .branch_offset_o(u3_branch_offset_o),
    .wb_pc_o(u3_wb_pc_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    valid_i = v;
    inst_i  = ins;
    pc_i    = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic s1e [4];
    logic v1e [4];
    logic s3e [4];
    logic v3e [4];

    // Reset overrides stall and flush and keeps stall_o low
    reset_i = 1'b1; stall_i = 1'b1; flush_i = 1'b1;
    drive(1'b1, 32'hE0821003, 32'h0000_0100);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    tick(); tick();
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_fields", {pc_o[15:0], cond_o, class_o, 2'b00, rd_o, rm_o}, 32'd0);
    chk("rst_flags", {27'd0, load_o, store_o, branch_o, link_o, wb_pc_o}, 32'd0);
    reset_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;

    // ADD R1,R2,R3
    drive(1'b1, 32'hE0821003, 32'h0000_0100);
    chk("add_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("add_valid", {31'd0, valid_o}, 32'd1);
    chk("add_fields", {16'd0, cond_o, 2'b00, class_o, opcode_o, rn_o}, 32'h0000_E042);
    chk("add_rd_rm", {24'd0, rd_o, rm_o}, 32'h13);
    chk("add_pc", pc_o, 32'h0000_0100);

    // LDR R4,[R5] then ADD R6,R4,R1 held by fetch while stalled
    drive(1'b1, 32'hE5954000, 32'h0000_0104);
    chk("ldr_stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("ldr_flags", {24'd0, class_o, 1'b0, valid_o, load_o, store_o, rd_o[1:0]}, 32'h0000_0058);
    chk("ldr_rn_rd", {24'd0, rn_o, rd_o}, 32'h54);
    drive(1'b1, 32'hE0846001, 32'h0000_0108);
    if (HAZ) begin
      s1e = '{1'b1, 1'b0, 1'b0, 1'b0};  v1e = '{1'b0, 1'b1, 1'b1, 1'b1};
      s3e = '{1'b1, 1'b1, 1'b1, 1'b0};  v3e = '{1'b0, 1'b0, 1'b0, 1'b1};
    end else begin
      s1e = '{1'b0, 1'b0, 1'b0, 1'b0};  v1e = '{1'b1, 1'b1, 1'b1, 1'b1};
      s3e = '{1'b0, 1'b0, 1'b0, 1'b0};  v3e = '{1'b1, 1'b1, 1'b1, 1'b1};
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lu_h1_stall%0d", k), {31'd0, stall_o}, {31'd0, s1e[k]});
      chk($sformatf("lu_h3_stall%0d", k), {31'd0, u3_stall_o}, {31'd0, s3e[k]});
      tick();
      chk($sformatf("lu_h1_valid%0d", k), {31'd0, valid_o}, {31'd0, v1e[k]});
      chk($sformatf("lu_h3_valid%0d", k), {31'd0, u3_valid_o}, {31'd0, v3e[k]});
      if (v3e[k]) chk($sformatf("lu_h3_rd%0d", k), {28'd0, u3_rd_o}, 32'd6);
    end
    chk("lu_h1_rd", {28'd0, rd_o}, 32'd6);

    // BL then flush
    drive(1'b1, 32'hEB000010, 32'h0000_0200);
    tick();
    chk("bl_flags", {26'd0, class_o, valid_o, branch_o, link_o, load_o}, 32'h0000_002E);
    chk("bl_offset", {8'd0, branch_offset_o}, 32'h0000_0010);
    flush_i = 1'b1;
    drive(1'b1, 32'hE0821003, 32'h0000_0204);
    tick();
    chk("flush_valid", {31'd0, valid_o}, 32'd0);
    flush_i = 1'b0;

    // MOV PC,LR then a two-cycle downstream stall
    drive(1'b1, 32'hE1A0F00E, 32'h0000_0300);
    tick();
    chk("mov_wbpc", {31'd0, wb_pc_o}, 32'd1);
    chk("mov_fields", {20'd0, opcode_o, rd_o, rm_o}, 32'h0000_0DFE);
    stall_i = 1'b1;
    drive(1'b1, 32'hE0821003, 32'h0000_0304);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("hold_flags%0d", k), {29'd0, valid_o, wb_pc_o, branch_o}, 32'h6);
      chk($sformatf("hold_fields%0d", k), {12'd0, opcode_o, rd_o, rm_o, rn_o, cond_o},
          32'h000D_FE0E);
      chk($sformatf("hold_pc%0d", k), pc_o, 32'h0000_0300);
    end
    stall_i = 1'b0;

    // CMP R15,#0 and CMP with an rd field of 15 never write the PC
    drive(1'b1, 32'hE35F0000, 32'h0000_0400);
    tick();
    chk("cmp_wbpc", {31'd0, wb_pc_o}, 32'd0);
    chk("cmp_bits", {24'd0, opcode_o, s_o, imm_o, valid_o, 1'b0}, 32'h0000_00AE);
    drive(1'b1, 32'hE35FF000, 32'h0000_0404);
    tick();
    chk("cmp_rd15_wbpc", {30'd0, valid_o, wb_pc_o}, 32'h2);

    // STR R15 does not write the PC, LDR PC does
    drive(1'b1, 32'hE58FF000, 32'h0000_0408);
    tick();
    chk("str_pc", {28'd0, valid_o, load_o, store_o, wb_pc_o}, 32'hA);
    drive(1'b1, 32'hE59FF000, 32'h0000_040C);
    tick();
    chk("ldr_pc", {28'd0, valid_o, load_o, store_o, wb_pc_o}, 32'hD);

    // Undefined encodings are dropped
    drive(1'b1, 32'hE8BD8000, 32'h0000_0410);
    tick();
    chk("ldm_undef", {30'd0, valid_o, load_o}, 32'd0);
    drive(1'b1, 32'hEC000000, 32'h0000_0414);
    tick();
    chk("cls11_undef", {29'd0, valid_o, class_o}, 32'h3);

    // Immediate DP ignores the rm field; register DP checks it
    drive(1'b1, 32'hE5954000, 32'h0000_0500);
    tick();
    drive(1'b1, 32'hE2816004, 32'h0000_0504);
    chk("imm_nohaz", {31'd0, stall_o}, 32'd0);
    tick();
    chk("imm_valid", {31'd0, valid_o}, 32'd1);
    drive(1'b1, 32'hE5954000, 32'h0000_0508);
    tick();
    drive(1'b1, 32'hE0816004, 32'h0000_050C);
    chk("rm_haz", {31'd0, u3_stall_o}, {31'd0, HAZ});
    tick();
    chk("bubble_stall", {31'd0, u3_stall_o}, {31'd0, HAZ});

    // Reset in the middle of a bubble
    reset_i = 1'b1;
    #1;
    chk("rstb_stall_now", {31'd0, u3_stall_o}, 32'd0);
    tick();
    chk("rstb_valid", {31'd0, u3_valid_o}, 32'd0);
    reset_i = 1'b0;
    drive(1'b1, 32'hE0816004, 32'h0000_0510);
    chk("rstb_stall_after", {31'd0, u3_stall_o}, 32'd0);
    tick();
    chk("rstb_first_valid", {27'd0, u3_valid_o, u3_rd_o}, 32'h16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
